i2c_tx_fifo: RTL

- Transmit FIFO between the APB register block and the I2C core, in the single pclk_i domain.
- Write side: the register block's transmit byte plus its level-style write enable. That enable rises in the APB access phase and stays high until the bus goes idle.
- Read side: the I2C core pops one byte per transmitted data phase.
- Provides first-word-fall-through head data, occupancy, and sticky overflow/underflow error flags for the status register.

---
 rtl/i2c_pkg.sv | 13 +
 rtl/i2c_rise_detect.sv | 21 ++
 rtl/i2c_tx_fifo.sv | 116 +++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C FIFO sizing and status-bit constants
package i2c_pkg;

  localparam int I2C_DATA_WIDTH    = 8;
  localparam int I2C_TX_FIFO_DEPTH = 8;

  // Bit positions of the FIFO flags inside the status register
  localparam int I2C_STAT_FULL_BIT      = 0;
  localparam int I2C_STAT_EMPTY_BIT     = 1;
  localparam int I2C_STAT_OVERFLOW_BIT  = 2;
  localparam int I2C_STAT_UNDERFLOW_BIT = 3;

endpackage

// File: rtl/i2c_rise_detect.sv
// rtl/i2c_rise_detect.sv - one-cycle strobe on the rising edge of a level request
module i2c_rise_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/i2c_tx_fifo.sv
// rtl/i2c_tx_fifo.sv - FWFT transmit FIFO between the APB register block and the I2C core
module i2c_tx_fifo
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = I2C_DATA_WIDTH,
  parameter int DEPTH      = I2C_TX_FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  pclk_i,
  input  logic                  preset_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  write_enable_i,
  input  logic                  read_enable_i,
  input  logic                  clear_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  push, push_ok, pop_ok, empty, full, mem_we;

  // The register block holds its write enable for the whole APB access
  i2c_rise_detect u_push_detect (
    .clk_i   (pclk_i),
    .rst_i   (preset_i),
    .level_i (write_enable_i),
    .rise_o  (push)
  );

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign pop_ok  = read_enable_i & ~empty;
  // A full FIFO still takes a push when the same cycle frees a slot
  assign push_ok = push & (~full | pop_ok);
  assign mem_we  = push_ok & ~clear_i;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (push && !push_ok) begin
        overflow_d = 1'b1;
      end
      if (read_enable_i && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o      = mem_q[rd_ptr_q];
  assign empty_o     = empty;
  assign full_o      = full;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule
